exec_dmem: RTL and testbench
============================

// Module: exec_dmem
// PURPOSE
//  Word-addressed data memory that answers the execute stage's load/store port.
//  It takes address, write strobe and write data each cycle, and returns read data
//  exactly one cycle later. That matches the execute stage's registered load-select,
//  where result = ldst data when the previous cycle was a load.
//  A secondary host port preloads and dumps memory while the core is halted.
//  An out-of-range detector raises a sticky error flag.
// PARAMETERS
//  ADDR_W      16  width of core/host address (word address)
//  DATA_W      32  data word width (matches operand width W_OPR)
//  DEPTH_LOG2  10  log2 of implemented words; 1024 words by default
// PORTS
//  clk           in   1           clock, rising edge
//  reset         in   1           asynchronous, active-low reset
//  addr_i        in   ADDR_W      core load/store word address (sampled every cycle)
//  write_i       in   1           core store strobe (already qualified by valid upstream)
//  wdata_i       in   DATA_W      core store data
//  rdata_o       out  DATA_W      core read data for addr_i of previous cycle
//  halt_i        in   1           core halted; host port enabled, core port ignored
//  host_req_i    in   1           host request; hold until host_ack_o
//  host_we_i     in   1           host write (1) / read (0)
//  host_addr_i   in   ADDR_W      host word address
//  host_wdata_i  in   DATA_W      host write data
//  host_ack_o    out  1           one-cycle pulse: request completed
//  host_rdata_o  out  DATA_W      host read data, valid while host_ack_o=1 for a read
//  err_o         out  1           sticky: out-of-range access seen since reset
// BEHAVIOUR
//  Reset: rdata_o=0, host_ack_o=0, host_rdata_o=0, err_o=0, host FSM=IDLE.
//  Array contents are not reset; benches preload them via the host port.
//  In range: addr[ADDR_W-1:DEPTH_LOG2]==0. Index = addr[DEPTH_LOG2-1:0].
//  Core port, active when halt_i=0:
//  - every edge, rdata_o <= mem[addr_i]; latency 1; no handshake, no stall.
//  - write_i=1: mem[addr_i] <= wdata_i on the same edge.
//  - same-cycle read of the written address is write-first: rdata_o=wdata_i.
//  - back-to-back store then load to the same address returns the stored data.
//  - out of range: the store is dropped, rdata_o <= 0, err_o <= 1.
//  - halt_i=1: write_i is ignored and rdata_o holds its last value.
//  Host FSM, advances only while halt_i=1:
//  - IDLE: host_req_i=1 -> ACCESS. Host address and data are latched on entry.
//  - ACCESS: performs one array read or write -> RESP.
//  - RESP: host_ack_o=1 for exactly one cycle; host_rdata_o valid for reads -> DONE.
//  - DONE: waits for host_req_i=0 -> IDLE. A held request is never serviced twice.
//  - Minimum latency: 2 cycles from request sampled to ack.
//  - Host out-of-range access: write dropped, read data 0, err_o <= 1, ack still given.
//  - halt_i falls while in ACCESS or RESP: the FSM completes RESP (the array op has
//    already happened), then waits in DONE. The core port takes effect from the
//    cycle after halt_i=0.
//  - halt_i=0 while in IDLE: host_req_i is not sampled and the request stays pending.
//  Only one array port is used per cycle, so a single-port RAM is inferable. The
//  array port is muxed by halt_i; host_rdata_o has its own output register.
//  err_o clears only on reset.
//  Asserting reset mid-operation aborts the host FSM to IDLE with no ack.
//  Any in-flight array write on that edge is not guaranteed.
// TESTING
//  1. Preload: halt=1, host writes mem[5]=0xDEADBEEF -> ack 2 cycles after req.
//     Host read of 5 -> host_rdata_o=0xDEADBEEF with ack.
//  2. Core load: halt=0, addr_i=5 at cycle N -> rdata_o=0xDEADBEEF at cycle N+1.
//  3. Write-first: write_i=1, addr_i=7, wdata_i=0x12345678 -> rdata_o=0x12345678 next
//     cycle. Load of 7 on the following cycle returns the same value.
//  4. Out of range: addr_i=0x0400 store of 0x1 -> err_o=1 and stays 1, rdata_o=0.
//     Host read of 0x0000 is unchanged.
//  5. Halt gating: halt=0 with host_req held -> no ack. Raise halt -> exactly one ack.
//     Keep req high 5 more cycles -> no second ack.
//  6. Reset mid-op: async reset low during ACCESS -> host_ack_o=0, rdata_o=0, err_o=0.
//     A new request after release completes normally.

Source files
------------

// File: rtl/exec_dmem.sv
// Execute-stage data memory: one-cycle-latency core load/store port plus a
// halted-core host port for preload/dump, with a sticky out-of-range flag.
module exec_dmem #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              write_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              halt_i,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_ack_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    logic [ADDR_W-1:0]     r_haddr;
    logic [DATA_W-1:0]     r_hwdata;
    logic                  r_hwe;
    logic [DATA_W-1:0]     r_rdata;
    logic [DATA_W-1:0]     r_hrdata;
    logic                  r_ack;
    logic                  r_err;

    logic                  w_host;
    logic                  w_core;
    logic [ADDR_W-1:0]     w_addr;
    logic                  w_inr;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_we;
    logic [DATA_W-1:0]     w_wd;
    logic [DATA_W-1:0]     w_rd;

    // ACCESS owns the single array port even if halt has already dropped,
    // so the core port only resumes once the host op has left the array.
    assign w_host = (r_state == S_ACCESS);
    assign w_core = !halt_i && !w_host;
    assign w_addr = w_host ? r_haddr : addr_i;
    assign w_inr  = (w_addr[ADDR_W-1:DEPTH_LOG2] == '0);
    assign w_idx  = w_addr[DEPTH_LOG2-1:0];
    assign w_we   = w_inr && (w_host ? r_hwe : (w_core && write_i));
    assign w_wd   = w_host ? r_hwdata : wdata_i;
    assign w_rd   = r_mem[w_idx];

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_idx] <= w_wd;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:   if (halt_i && host_req_i) w_state_nx = S_ACCESS;
            S_ACCESS: w_state_nx = S_RESP;
            S_RESP:   w_state_nx = S_DONE;
            S_DONE:   if (halt_i && !host_req_i) w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_haddr  <= '0;
            r_hwdata <= '0;
            r_hwe    <= 1'b0;
            r_rdata  <= '0;
            r_hrdata <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ack   <= w_host;
            if (r_state == S_IDLE && w_state_nx == S_ACCESS) begin
                r_haddr  <= host_addr_i;
                r_hwdata <= host_wdata_i;
                r_hwe    <= host_we_i;
            end
            if (w_host) begin
                r_hrdata <= w_inr ? w_rd : '0;
                if (!w_inr) r_err <= 1'b1;
            end
            if (w_core) begin
                if (!w_inr) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end else begin
                    r_rdata <= write_i ? wdata_i : w_rd;
                end
            end
        end
    end

    assign rdata_o      = r_rdata;
    assign host_ack_o   = r_ack;
    assign host_rdata_o = r_hrdata;
    assign err_o        = r_err;

endmodule

// File: tb/tb_exec_dmem.sv
// Directed bench for exec_dmem: host preload, core loads/stores,
// range errors, halt gating and mid-operation reset.
module tb_exec_dmem;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr_i;
    logic        write_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        halt_i;
    logic        host_req_i;
    logic        host_we_i;
    logic [15:0] host_addr_i;
    logic [31:0] host_wdata_i;
    logic        host_ack_o;
    logic [31:0] host_rdata_o;
    logic        err_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] sbq [$];

    exec_dmem dut (
        .clk         (clk),
        .reset       (reset),
        .addr_i      (addr_i),
        .write_i     (write_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .halt_i      (halt_i),
        .host_req_i  (host_req_i),
        .host_we_i   (host_we_i),
        .host_addr_i (host_addr_i),
        .host_wdata_i(host_wdata_i),
        .host_ack_o  (host_ack_o),
        .host_rdata_o(host_rdata_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Core access; expected read data goes to the scoreboard at drive time.
    task automatic core(input string tag, input logic we,
                        input logic [15:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
        logic [31:0] e;
        addr_i  = a;
        write_i = we;
        wdata_i = d;
        sbq.push_back(exp);
        tick();
        write_i = 1'b0;
        e = sbq.pop_front();
        chk(tag, rdata_o, e);
    endtask

    // Host transaction with bounded wait; checks latency, read data, ack width.
    task automatic host(input string tag, input logic we,
                        input logic [15:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
        int lat;
        logic [31:0] e;
        host_we_i    = we;
        host_addr_i  = a;
        host_wdata_i = d;
        host_req_i   = 1'b1;
        if (!we) sbq.push_back(exp);
        lat = 0;
        while (!host_ack_o && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 2);
        if (!we) begin
            e = sbq.pop_front();
            chk({tag, "_rd"}, host_rdata_o, e);
        end
        host_req_i = 1'b0;
        tick();
        chk({tag, "_ack1"}, {31'd0, host_ack_o}, 32'd0);
        tick();
    endtask

    initial begin
        int acks;
        reset        = 1'b0;
        halt_i       = 1'b1;
        addr_i       = '0;
        write_i      = 1'b0;
        wdata_i      = '0;
        host_req_i   = 1'b0;
        host_we_i    = 1'b0;
        host_addr_i  = '0;
        host_wdata_i = '0;
        #12;
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_ack", {31'd0, host_ack_o}, 32'd0);
        chk("rst_hrdata", host_rdata_o, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        reset = 1'b1;
        tick();

        host("hw5", 1'b1, 16'd5, 32'hDEADBEEF, 32'd0);
        host("hw0", 1'b1, 16'd0, 32'hA5A50000, 32'd0);
        host("hr5", 1'b0, 16'd5, 32'd0, 32'hDEADBEEF);

        halt_i = 1'b0;
        core("ld5", 1'b0, 16'd5, 32'd0, 32'hDEADBEEF);
        core("st7", 1'b1, 16'd7, 32'h12345678, 32'h12345678);
        core("ld7", 1'b0, 16'd7, 32'd0, 32'h12345678);
        core("ld0", 1'b0, 16'd0, 32'd0, 32'hA5A50000);
        core("oor_st", 1'b1, 16'h0400, 32'd1, 32'd0);
        chk("oor_err", {31'd0, err_o}, 32'd1);
        core("ld5b", 1'b0, 16'd5, 32'd0, 32'hDEADBEEF);
        chk("err_sticky", {31'd0, err_o}, 32'd1);

        halt_i = 1'b1;
        host("hr0", 1'b0, 16'd0, 32'd0, 32'hA5A50000);
        host("hr_oor", 1'b0, 16'h0800, 32'd0, 32'd0);

        halt_i      = 1'b0;
        host_we_i   = 1'b0;
        host_addr_i = 16'd7;
        host_req_i  = 1'b1;
        acks = 0;
        repeat (5) begin
            tick();
            if (host_ack_o) acks++;
        end
        chk("nohalt_ack", acks, 0);
        halt_i  = 1'b1;
        addr_i  = 16'd5;
        write_i = 1'b1;
        wdata_i = 32'h0;
        repeat (8) begin
            tick();
            if (host_ack_o) begin
                acks++;
                chk("held_rd", host_rdata_o, 32'h12345678);
            end
        end
        chk("one_ack", acks, 1);
        chk("halt_hold", rdata_o, 32'hDEADBEEF);
        write_i    = 1'b0;
        host_req_i = 1'b0;
        tick();
        halt_i = 1'b0;
        tick();
        core("ld5_nowr", 1'b0, 16'd5, 32'd0, 32'hDEADBEEF);

        halt_i       = 1'b1;
        host_we_i    = 1'b1;
        host_addr_i  = 16'd9;
        host_wdata_i = 32'hCAFEF00D;
        host_req_i   = 1'b1;
        tick();
        #1 reset = 1'b0;
        #1;
        chk("mid_ack", {31'd0, host_ack_o}, 32'd0);
        chk("mid_rdata", rdata_o, 32'd0);
        chk("mid_err", {31'd0, err_o}, 32'd0);
        host_req_i = 1'b0;
        #1 reset = 1'b1;
        tick();
        tick();
        chk("post_ack", {31'd0, host_ack_o}, 32'd0);
        host("hr5_post", 1'b0, 16'd5, 32'd0, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
